// File: rtl/audio_out_stage.sv
// Multi-channel audio output stage: per-channel signed gain with saturation feeding a FWFT frame FIFO.
// Optional macro AUDIO_OUT_ROUND_EN: round half toward +inf before the shift instead of truncating.
module audio_out_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned GAIN_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 10,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_CH*DATA_WIDTH-1:0]     in_data,
  input  logic                             in_wr_en,
  output logic                             in_full,
  input  logic [NUM_CH*GAIN_WIDTH-1:0]     gain,
  output logic [NUM_CH*DATA_WIDTH-1:0]     out_data,
  input  logic                             out_rd_en,
  output logic                             out_empty,
  output logic [$clog2(FIFO_DEPTH):0]      out_count,
  output logic                             overflow,
  output logic                             sat
);

  localparam int unsigned PW      = DATA_WIDTH + GAIN_WIDTH;
  localparam int unsigned FRAME_W = NUM_CH * DATA_WIDTH;
  localparam int unsigned GAINS_W = NUM_CH * GAIN_WIDTH;
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CW      = AW + 1;

  // Clip bounds expressed at product width so the comparison stays signed and exact.
  localparam logic signed [PW-1:0] SAT_MAX =
    $signed({{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [PW-1:0] SAT_MIN =
    $signed({{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}});
`ifdef AUDIO_OUT_ROUND_EN
  localparam logic signed [PW-1:0] RND_HALF =
    $signed({{(PW-1){1'b0}}, 1'b1} << (FRAC_BITS-1));
`endif

  // Capture stage
  logic               r_v1;
  logic [FRAME_W-1:0] r_d1;
  logic [GAINS_W-1:0] r_g1;
  // Scale stage
  logic               r_v2;
  logic [FRAME_W-1:0] r_d2;
  // Frame storage and bookkeeping
  logic [FRAME_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_overflow;
  logic               r_sat;

  logic               w_accept;
  logic               w_pop;
  logic [CW-1:0]      w_level;
  logic [FRAME_W-1:0] w_s2_data;
  logic [NUM_CH-1:0]  w_clip;
  logic signed [PW-1:0] w_a   [NUM_CH];
  logic signed [PW-1:0] w_b   [NUM_CH];
  logic signed [PW-1:0] w_sum [NUM_CH];
  logic signed [PW-1:0] w_sh  [NUM_CH];

  // Reservation covers frames still in the pipeline, so S2 never has to stall.
  assign w_level   = r_count + CW'(r_v1) + CW'(r_v2);
  assign in_full   = (w_level >= CW'(FIFO_DEPTH));
  assign out_empty = (r_count == '0);
  assign w_accept  = in_wr_en && !in_full;
  assign w_pop     = out_rd_en && !out_empty;

  assign out_data  = out_empty ? '0 : r_mem[r_rd_ptr];
  assign out_count = r_count;
  assign overflow  = r_overflow;
  assign sat       = r_sat;

  // Full-precision multiply, optional rounding, arithmetic shift, clip per channel.
  always_comb begin
    w_s2_data = '0;
    w_clip    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_a[c] = $signed({{GAIN_WIDTH{r_d1[c*DATA_WIDTH+DATA_WIDTH-1]}},
                        r_d1[c*DATA_WIDTH +: DATA_WIDTH]});
      w_b[c] = $signed({{DATA_WIDTH{r_g1[c*GAIN_WIDTH+GAIN_WIDTH-1]}},
                        r_g1[c*GAIN_WIDTH +: GAIN_WIDTH]});
`ifdef AUDIO_OUT_ROUND_EN
      w_sum[c] = (w_a[c] * w_b[c]) + RND_HALF;
`else
      w_sum[c] = w_a[c] * w_b[c];
`endif
      w_sh[c] = w_sum[c] >>> FRAC_BITS;
      if (w_sh[c] > SAT_MAX) begin
        w_s2_data[c*DATA_WIDTH +: DATA_WIDTH] = SAT_MAX[DATA_WIDTH-1:0];
        w_clip[c] = 1'b1;
      end else if (w_sh[c] < SAT_MIN) begin
        w_s2_data[c*DATA_WIDTH +: DATA_WIDTH] = SAT_MIN[DATA_WIDTH-1:0];
        w_clip[c] = 1'b1;
      end else begin
        w_s2_data[c*DATA_WIDTH +: DATA_WIDTH] = w_sh[c][DATA_WIDTH-1:0];
      end
    end
  end

  // Pipeline, pointers, occupancy and sticky flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_v1       <= 1'b0;
      r_d1       <= '0;
      r_g1       <= '0;
      r_v2       <= 1'b0;
      r_d2       <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_sat      <= 1'b0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_d1 <= in_data;
        r_g1 <= gain;
      end
      r_v2 <= r_v1;
      if (r_v1) begin
        r_d2 <= w_s2_data;
      end
      if (r_v2) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({r_v2, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (in_wr_en && in_full) begin
        r_overflow <= 1'b1;
      end
      if (r_v1 && (|w_clip)) begin
        r_sat <= 1'b1;
      end
    end
  end

  // Storage is not reset; out_data is masked to zero while empty.
  always_ff @(posedge clock) begin
    if (r_v2) begin
      r_mem[r_wr_ptr] <= r_d2;
    end
  end

endmodule

// File: tb/tb_audio_out_stage.sv
// Directed self-checking bench for audio_out_stage with default parameters (2 x 32-bit, Q5.10 gain, 16 frames).
module tb_audio_out_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic        in_wr_en;
  logic        in_full;
  logic [31:0] gain;
  logic [63:0] out_data;
  logic        out_rd_en;
  logic        out_empty;
  logic [4:0]  out_count;
  logic        overflow;
  logic        sat;

  int n_cmp  = 0;
  int n_fail = 0;

  audio_out_stage dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .in_wr_en (in_wr_en),
    .in_full  (in_full),
    .gain     (gain),
    .out_data (out_data),
    .out_rd_en(out_rd_en),
    .out_empty(out_empty),
    .out_count(out_count),
    .overflow (overflow),
    .sat      (sat)
  );

  always #5 clock = ~clock;

  // Frame n: L = 100+n, R = -(200+n)
  function automatic logic [63:0] frm(input int n);
    return {32'(-(200 + n)), 32'(100 + n)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_wr_en = 1'b0;
    out_rd_en = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_wr_en = 1'b0;
    out_rd_en = 1'b0;
    in_data = '0;
    gain = '0;
    tick();
    tick();
    reset = 1'b0;
    n_cmp++; if (out_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", out_empty); end
    n_cmp++; if (in_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", in_full); end
    n_cmp++; if (out_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", out_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++; if (sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b want 0", sat); end
    n_cmp++; if (out_data !== 64'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data); end
  endtask

  task automatic test_unity();
    gain = {16'h0400, 16'h0400};
    in_data = {32'(-1000), 32'd1000};
    in_wr_en = 1'b1;
    tick();
    in_wr_en = 1'b0;
    tick();
    n_cmp++; if (out_empty !== 1'b1) begin n_fail++; $display("FAIL unity_latency2: got empty=%b want 1", out_empty); end
    tick();
    n_cmp++; if (out_empty !== 1'b0) begin n_fail++; $display("FAIL unity_latency3: got empty=%b want 0", out_empty); end
    n_cmp++; if (out_data !== {32'(-1000), 32'd1000}) begin n_fail++; $display("FAIL unity_data: got %h want %h", out_data, {32'(-1000), 32'd1000}); end
    n_cmp++; if (out_count !== 5'd1) begin n_fail++; $display("FAIL unity_count: got %0d want 1", out_count); end
    out_rd_en = 1'b1;
    tick();
    out_rd_en = 1'b0;
    n_cmp++; if (out_empty !== 1'b1) begin n_fail++; $display("FAIL unity_pop_empty: got %b want 1", out_empty); end
    n_cmp++; if (out_count !== 5'd0) begin n_fail++; $display("FAIL unity_pop_count: got %0d want 0", out_count); end
    // Pop while empty is ignored.
    out_rd_en = 1'b1;
    tick();
    out_rd_en = 1'b0;
    n_cmp++; if (out_count !== 5'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL empty_pop: got count=%0d ovf=%b want 0/0", out_count, overflow); end
  endtask

  task automatic test_gain_sign();
    gain = {16'hFC00, 16'h0000};
    in_data = {32'd555, 32'd1234};
    in_wr_en = 1'b1;
    tick();
    in_wr_en = 1'b0;
    tick();
    tick();
    n_cmp++; if (out_data !== {32'(-555), 32'd0}) begin n_fail++; $display("FAIL mute_invert: got %h want %h", out_data, {32'(-555), 32'd0}); end
    n_cmp++; if (sat !== 1'b0) begin n_fail++; $display("FAIL mute_invert_sat: got %b want 0", sat); end
    out_rd_en = 1'b1;
    tick();
    out_rd_en = 1'b0;
  endtask

  task automatic test_rounding();
    logic [63:0] exp_v;
`ifdef AUDIO_OUT_ROUND_EN
    exp_v = {32'(-1), 32'd2};
`else
    exp_v = {32'(-2), 32'd1};
`endif
    gain = {16'h0200, 16'h0200};
    in_data = {32'(-3), 32'd3};
    in_wr_en = 1'b1;
    tick();
    in_wr_en = 1'b0;
    tick();
    tick();
    n_cmp++; if (out_data !== exp_v) begin n_fail++; $display("FAIL rounding: got %h want %h", out_data, exp_v); end
    out_rd_en = 1'b1;
    tick();
    out_rd_en = 1'b0;
  endtask

  task automatic test_saturation();
    gain = {16'h0800, 16'h0800};
    in_data = {32'h8000_0000, 32'h7FFF_FFFF};
    in_wr_en = 1'b1;
    tick();
    in_wr_en = 1'b0;
    tick();
    tick();
    n_cmp++; if (out_data !== {32'h8000_0000, 32'h7FFF_FFFF}) begin n_fail++; $display("FAIL sat_data: got %h want %h", out_data, {32'h8000_0000, 32'h7FFF_FFFF}); end
    n_cmp++; if (sat !== 1'b1) begin n_fail++; $display("FAIL sat_flag: got %b want 1", sat); end
    out_rd_en = 1'b1;
    tick();
    out_rd_en = 1'b0;
    // A clean frame afterwards must leave the flag set.
    gain = {16'h0400, 16'h0400};
    in_data = frm(0);
    in_wr_en = 1'b1;
    tick();
    in_wr_en = 1'b0;
    tick();
    tick();
    n_cmp++; if (out_data !== frm(0)) begin n_fail++; $display("FAIL sat_clean_data: got %h want %h", out_data, frm(0)); end
    n_cmp++; if (sat !== 1'b1) begin n_fail++; $display("FAIL sat_sticky: got %b want 1", sat); end
    out_rd_en = 1'b1;
    tick();
    out_rd_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    gain = {16'h0400, 16'h0400};
    for (int k = 0; k < 7; k++) begin
      in_data = frm(k);
      in_wr_en = 1'b1;
      tick();
    end
    n_cmp++; if (out_count !== 5'd5) begin n_fail++; $display("FAIL mid_pre_count: got %0d want 5", out_count); end
    reset = 1'b1;
    in_data = frm(7);
    tick();
    reset = 1'b0;
    in_wr_en = 1'b0;
    n_cmp++; if (out_empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty: got %b want 1", out_empty); end
    n_cmp++; if (out_count !== 5'd0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", out_count); end
    n_cmp++; if (sat !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL mid_flags: got sat=%b ovf=%b want 0/0", sat, overflow); end
    n_cmp++; if (in_full !== 1'b0) begin n_fail++; $display("FAIL mid_full: got %b want 0", in_full); end
    n_cmp++; if (out_data !== 64'd0) begin n_fail++; $display("FAIL mid_data: got %h want 0", out_data); end
    for (int k = 0; k < 4; k++) tick();
    n_cmp++; if (out_empty !== 1'b1 || out_count !== 5'd0) begin n_fail++; $display("FAIL mid_stale: got empty=%b count=%0d want 1/0", out_empty, out_count); end
    in_data = frm(50);
    in_wr_en = 1'b1;
    tick();
    in_wr_en = 1'b0;
    tick();
    tick();
    n_cmp++; if (out_data !== frm(50) || out_count !== 5'd1) begin n_fail++; $display("FAIL mid_after: got %h count=%0d want %h/1", out_data, out_count, frm(50)); end
    out_rd_en = 1'b1;
    tick();
    out_rd_en = 1'b0;
  endtask

  task automatic test_full_overflow();
    do_reset();
    gain = {16'h0400, 16'h0400};
    for (int k = 0; k < 20; k++) begin
      in_data = frm(k);
      in_wr_en = 1'b1;
      tick();
      if (k == 14) begin
        n_cmp++; if (in_full !== 1'b0) begin n_fail++; $display("FAIL full_early: got %b want 0", in_full); end
      end
      if (k == 15) begin
        n_cmp++; if (in_full !== 1'b1) begin n_fail++; $display("FAIL full_rise: got %b want 1", in_full); end
      end
    end
    in_wr_en = 1'b0;
    tick();
    tick();
    n_cmp++; if (out_count !== 5'd16) begin n_fail++; $display("FAIL full_count: got %0d want 16", out_count); end
    n_cmp++; if (in_full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b want 1", in_full); end
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_overflow: got %b want 1", overflow); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (out_data !== frm(i)) begin n_fail++; $display("FAIL full_order[%0d]: got %h want %h", i, out_data, frm(i)); end
      out_rd_en = 1'b1;
      tick();
    end
    out_rd_en = 1'b0;
    n_cmp++; if (out_empty !== 1'b1 || out_count !== 5'd0) begin n_fail++; $display("FAIL full_drain: got empty=%b count=%0d want 1/0", out_empty, out_count); end
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_concurrent();
    do_reset();
    gain = {16'h0400, 16'h0400};
    for (int k = 0; k < 16; k++) begin
      in_data = frm(k);
      in_wr_en = 1'b1;
      tick();
    end
    in_wr_en = 1'b0;
    tick();
    tick();
    n_cmp++; if (out_count !== 5'd16 || in_full !== 1'b1) begin n_fail++; $display("FAIL conc_fill: got count=%0d full=%b want 16/1", out_count, in_full); end
    out_rd_en = 1'b1;
    tick();
    out_rd_en = 1'b0;
    n_cmp++; if (in_full !== 1'b0 || out_count !== 5'd15) begin n_fail++; $display("FAIL conc_fall: got full=%b count=%0d want 0/15", in_full, out_count); end
    in_data = frm(16);
    in_wr_en = 1'b1;
    tick();
    in_wr_en = 1'b0;
    n_cmp++; if (in_full !== 1'b1) begin n_fail++; $display("FAIL conc_reserve: got %b want 1", in_full); end
    tick();
    // FIFO write and pop land on the same edge.
    n_cmp++; if (out_data !== frm(1)) begin n_fail++; $display("FAIL conc_head1: got %h want %h", out_data, frm(1)); end
    out_rd_en = 1'b1;
    tick();
    n_cmp++; if (out_count !== 5'd15) begin n_fail++; $display("FAIL conc_same_edge: got %0d want 15", out_count); end
    for (int k = 0; k < 8; k++) begin
      in_data = frm(17 + k);
      in_wr_en = 1'b1;
      n_cmp++; if (out_data !== frm(2 + k)) begin n_fail++; $display("FAIL conc_stream[%0d]: got %h want %h", k, out_data, frm(2 + k)); end
      tick();
    end
    in_wr_en = 1'b0;
    out_rd_en = 1'b0;
    n_cmp++; if (out_count !== 5'd13 || overflow !== 1'b0) begin n_fail++; $display("FAIL conc_steady: got count=%0d ovf=%b want 13/0", out_count, overflow); end
    tick();
    tick();
    n_cmp++; if (out_count !== 5'd15) begin n_fail++; $display("FAIL conc_settle: got %0d want 15", out_count); end
    for (int i = 10; i < 25; i++) begin
      n_cmp++; if (out_data !== frm(i)) begin n_fail++; $display("FAIL conc_drain[%0d]: got %h want %h", i, out_data, frm(i)); end
      out_rd_en = 1'b1;
      tick();
    end
    out_rd_en = 1'b0;
    n_cmp++; if (out_empty !== 1'b1 || overflow !== 1'b0) begin n_fail++; $display("FAIL conc_end: got empty=%b ovf=%b want 1/0", out_empty, overflow); end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_gain_sign();
    test_rounding();
    test_saturation();
    test_reset_mid();
    test_full_overflow();
    test_concurrent();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
